// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM:
// opcodes, state encodings, ALUOp / mux-select codes and the control word.
package mips_ctrl_pkg;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // State encodings (visible on state_dbg)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_JEX     = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;

  // ALUOp codes consumed by ALUcontrol
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B source selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

  // States that wait on the memory handshake and run the wait counter
  function automatic logic is_wait_state(input logic [3:0] st);
    return (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode and memory handshake in,
// mux selects, strobes and status out.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state_dbg;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state_dbg, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state_dbg, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control-word decode. FETCH's pc_write/ir_write
// depend on mem_ready and are added by the top level.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_word_t cw
);

  // Moore decode of the current state; unlisted fields stay 0
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.i_or_d    = 1'b0;
        cw.alu_src_a = 1'b0;
        cw.alu_src_b = SRCB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        cw.alu_src_a = 1'b0;
        cw.alu_src_b = SRCB_IMM_SH;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.mem_read = 1'b1;
        cw.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_dst    = 1'b0;
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_write = 1'b1;
        cw.i_or_d    = 1'b1;
      end
      S_RTYPEEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_B;
        cw.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        cw.reg_dst    = 1'b1;
        cw.mem_to_reg = 1'b0;
        cw.reg_write  = 1'b1;
      end
      S_BEQEX: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_B;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCSRC_ALUOUT;
      end
      S_JEX: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        cw.reg_dst    = 1'b0;
        cw.mem_to_reg = 1'b0;
        cw.reg_write  = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state logic, bounded memory-wait counter and status pulses.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit HAS_ADDI    = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  mips_multicycle_ctrl_if.master bus
);

  localparam int             CW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit             TO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [CW-1:0]  TO_LAST = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  logic [3:0]    state_r;
  logic [3:0]    next_state_s;
  logic [CW-1:0] wait_cnt_r;
  logic          illegal_s;
  logic          timeout_s;
  logic          timeout_hit_s;
  logic          illegal_op_r;
  logic          mem_timeout_r;
  ctrl_word_t    cw_s;
  ctrl_word_t    out_s;

  mips_ctrl_decode u_decode (
    .state (state_r),
    .cw    (cw_s)
  );

  // A wait state has used up its budget with memory still not ready
  always_comb begin
    if (TO_EN && !bus.mem_ready && (wait_cnt_r == TO_LAST)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Next-state selection and abort/illegal pulse requests
  always_comb begin
    next_state_s = state_r;
    illegal_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (bus.mem_ready) begin
          next_state_s = S_DECODE;
        end else if (timeout_hit_s) begin
          next_state_s = S_FETCH;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_RTYPEEX;
          OP_BEQ:       next_state_s = S_BEQEX;
          OP_J:         next_state_s = S_JEX;
          OP_ADDI: begin
            if (HAS_ADDI) begin
              next_state_s = S_ADDIEX;
            end else begin
              next_state_s = S_FETCH;
              illegal_s    = 1'b1;
            end
          end
          default: begin
            next_state_s = S_FETCH;
            illegal_s    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW) begin
          next_state_s = S_MEMRD;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_MEMRD: begin
        if (bus.mem_ready) begin
          next_state_s = S_MEMWB;
        end else if (timeout_hit_s) begin
          next_state_s = S_FETCH;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (bus.mem_ready || timeout_hit_s) begin
          next_state_s = S_FETCH;
          timeout_s    = !bus.mem_ready;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_RTYPEEX: next_state_s = S_RTYPEWB;
      S_ADDIEX:  next_state_s = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_JEX, S_ADDIWB: next_state_s = S_FETCH;
      default:   next_state_s = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Memory wait counter: counts not-ready cycles, restarts on any state change or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
    end else if ((next_state_s != state_r) || timeout_s) begin
      wait_cnt_r <= '0;
    end else if (is_wait_state(state_r) && !bus.mem_ready) begin
      wait_cnt_r <= wait_cnt_r + CW'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // One-cycle status pulses, registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op_r  <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      illegal_op_r  <= illegal_s;
      mem_timeout_r <= timeout_s;
    end
  end

  // Output control word: FETCH loads PC/IR on mem_ready; everything quiet under reset
  always_comb begin
    out_s = '0;
    if (rst_n) begin
      out_s = cw_s;
      if (state_r == S_FETCH) begin
        out_s.pc_write = bus.mem_ready;
        out_s.ir_write = bus.mem_ready;
      end else begin
        out_s.pc_write = cw_s.pc_write;
        out_s.ir_write = cw_s.ir_write;
      end
    end else begin
      out_s = '0;
    end
  end

  assign bus.pc_write      = out_s.pc_write;
  assign bus.pc_write_cond = out_s.pc_write_cond;
  assign bus.i_or_d        = out_s.i_or_d;
  assign bus.mem_read      = out_s.mem_read;
  assign bus.mem_write     = out_s.mem_write;
  assign bus.ir_write      = out_s.ir_write;
  assign bus.mem_to_reg    = out_s.mem_to_reg;
  assign bus.reg_dst       = out_s.reg_dst;
  assign bus.reg_write     = out_s.reg_write;
  assign bus.alu_src_a     = out_s.alu_src_a;
  assign bus.alu_src_b     = out_s.alu_src_b;
  assign bus.alu_op        = out_s.alu_op;
  assign bus.pc_source     = out_s.pc_source;
  assign bus.state_dbg     = state_r;
  assign bus.illegal_op    = illegal_op_r;
  assign bus.mem_timeout   = mem_timeout_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: two instances (default parameters, and
// MEM_TIMEOUT=4 / HAS_ADDI=0) share one stimulus stream. An instruction-level
// model predicts every output at each falling edge; directed sections pin
// the model with hand-computed expectations.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       mem_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  initial forever #5 clk = ~clk;

  mips_multicycle_ctrl_if if0 ();
  mips_multicycle_ctrl_if if1 ();

  assign if0.opcode    = opcode;
  assign if0.mem_ready = mem_ready;
  assign if1.opcode    = opcode;
  assign if1.mem_ready = mem_ready;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .HAS_ADDI(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mips_multicycle_ctrl #(.MEM_TIMEOUT(4),  .HAS_ADDI(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Observed outputs: {pw,pwc,iod,mr,mw,irw,m2r,rd,rw,sa,sb[2],op[2],ps[2],state[4],ill,to}
  logic [21:0] act0, act1;
  assign act0 = {if0.pc_write, if0.pc_write_cond, if0.i_or_d, if0.mem_read, if0.mem_write,
                 if0.ir_write, if0.mem_to_reg, if0.reg_dst, if0.reg_write, if0.alu_src_a,
                 if0.alu_src_b, if0.alu_op, if0.pc_source, if0.state_dbg, if0.illegal_op,
                 if0.mem_timeout};
  assign act1 = {if1.pc_write, if1.pc_write_cond, if1.i_or_d, if1.mem_read, if1.mem_write,
                 if1.ir_write, if1.mem_to_reg, if1.reg_dst, if1.reg_write, if1.alu_src_a,
                 if1.alu_src_b, if1.alu_op, if1.pc_source, if1.state_dbg, if1.illegal_op,
                 if1.mem_timeout};

  // ---------------- instruction-level reference model ----------------
  // cur = step currently executing; sq holds the remaining steps of the
  // instruction, filled when the instruction is decoded.
  int cur [2];
  int wcnt[2];
  int sq  [2][3];
  int slen[2];
  int spos[2];
  bit e_ill[2];
  bit e_to [2];

  task automatic load_seq(input int k, input int a, input int b, input int n);
    sq[k][0] = a; sq[k][1] = b; slen[k] = n; spos[k] = 0;
  endtask

  task automatic pop_step(input int k);
    if (spos[k] < slen[k]) begin
      cur[k] = sq[k][spos[k]];
      spos[k]++;
    end else begin
      cur[k] = 0;
    end
    wcnt[k] = 0;
  endtask

  task automatic model_reset(input int k);
    cur[k] = 0; wcnt[k] = 0; slen[k] = 0; spos[k] = 0; e_ill[k] = 1'b0; e_to[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    int tmo;
    bit addi;
    tmo  = (k == 0) ? 16 : 4;
    addi = (k == 0);
    e_ill[k] = 1'b0;
    e_to[k]  = 1'b0;
    if (cur[k] == 0 || cur[k] == 3 || cur[k] == 5) begin
      if (mem_ready) begin
        if (cur[k] == 0) begin
          cur[k] = 1; wcnt[k] = 0;
        end else begin
          pop_step(k);
        end
      end else if (tmo != 0 && wcnt[k] == tmo - 1) begin
        cur[k] = 0; slen[k] = 0; spos[k] = 0; wcnt[k] = 0; e_to[k] = 1'b1;
      end else begin
        wcnt[k]++;
      end
    end else if (cur[k] == 1) begin
      case (opcode)
        6'b100011, 6'b101011: load_seq(k, 2, 0, 1);
        6'b000000: load_seq(k, 6, 7, 2);
        6'b000100: load_seq(k, 8, 0, 1);
        6'b000010: load_seq(k, 9, 0, 1);
        6'b001000: begin
          if (addi) load_seq(k, 10, 11, 2);
          else begin load_seq(k, 0, 0, 0); e_ill[k] = 1'b1; end
        end
        default: begin load_seq(k, 0, 0, 0); e_ill[k] = 1'b1; end
      endcase
      pop_step(k);
    end else if (cur[k] == 2) begin
      if (opcode == 6'b100011) load_seq(k, 3, 4, 2);
      else load_seq(k, 5, 0, 1);
      pop_step(k);
    end else begin
      pop_step(k);
    end
  endtask

  // Control word each step must present, written straight from the state table
  function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, op, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = 10'b0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      0:  begin mr = 1'b1; sb = 2'b01; pw = rdy; irw = rdy; end
      1:  begin sb = 2'b11; end
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin mr = 1'b1; iod = 1'b1; end
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin mw = 1'b1; iod = 1'b1; end
      6:  begin sa = 1'b1; op = 2'b10; end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
      9:  begin pw = 1'b1; ps = 2'b10; end
      10: begin sa = 1'b1; sb = 2'b10; end
      11: begin rw = 1'b1; end
      default: begin end
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
  endfunction

  function automatic logic [21:0] exp_vec(input int k);
    if (!rst_n) return 22'd0;
    return {exp_ctrl(cur[k], mem_ready), 4'(cur[k]), e_ill[k], e_to[k]};
  endfunction

  // Advance the model on each rising edge; async reset clears it at once
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      model_reset(0); model_reset(1);
    end else begin
      model_step(0); model_step(1);
    end
  end

  // Compare both instances against the model on every falling edge
  initial forever begin
    @(negedge clk);
    n_tests++;
    if (act0 !== exp_vec(0)) begin
      n_fail++;
      $display("FAIL model_dut0 t=%0t got %h want %h", $time, act0, exp_vec(0));
    end
    n_tests++;
    if (act1 !== exp_vec(1)) begin
      n_fail++;
      $display("FAIL model_dut1 t=%0t got %h want %h", $time, act1, exp_vec(1));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, a, e);
    end
  endtask

  task automatic wait_st(input int k, input int target);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (((k == 0) ? int'(if0.state_dbg) : int'(if1.state_dbg)) == target) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_state dut%0d got timeout want state %0d", k, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen[5];
    int exp_seq[5];
    int rw_cnt;
    int n;
    int st;
    bit ok;
    int stall;
    int rst_hold;

    // Reset: all strobes and selects low
    #2;
    chk("reset_out_dut0", int'(act0), 0);
    chk("reset_out_dut1", int'(act1), 0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;

    // R-type with memory always ready: 0,1,6,7,0
    exp_seq = '{0, 1, 6, 7, 0};
    rw_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen[i] = int'(if0.state_dbg);
      rw_cnt += int'(if0.reg_write);
      if (i == 0) chk("rtype_fetch_pc_write", int'(if0.pc_write), 1);
      if (i == 2) chk("rtype_alu_op", int'(if0.alu_op), 2);
      if (i == 3) begin
        chk("rtype_reg_write", int'(if0.reg_write), 1);
        chk("rtype_reg_dst", int'(if0.reg_dst), 1);
      end
    end
    for (int i = 0; i < 5; i++) chk("rtype_state_seq", seen[i], exp_seq[i]);
    chk("rtype_reg_write_count", rw_cnt, 1);

    // lw with three not-ready cycles in MEMRD
    #1 opcode = 6'b100011;
    n = 0; ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      st = int'(if0.state_dbg);
      if (st == 2) begin
        #1 mem_ready = 1'b0;
      end else if (st == 3) begin
        n++;
        chk("lw_i_or_d", int'(if0.i_or_d), 1);
        if (n == 4) #1 mem_ready = 1'b1;
      end else if (st == 4) begin
        ok = 1'b1;
        chk("lw_mem_to_reg", int'(if0.mem_to_reg), 1);
        chk("lw_no_timeout_dut1", int'(if1.mem_timeout), 0);
      end
    end
    chk("lw_reached_memwb", int'(ok), 1);
    chk("lw_memrd_cycles", n, 4);

    // sw with memory stuck, MEM_TIMEOUT=4 instance
    #1 opcode = 6'b101011;
    n = 0; ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      st = int'(if1.state_dbg);
      if (st == 2) begin
        #1 mem_ready = 1'b0;
      end else if (st == 5) begin
        n++;
      end else if (st == 0 && n > 0) begin
        ok = 1'b1;
        chk("sw_timeout_pulse", int'(if1.mem_timeout), 1);
      end
    end
    chk("sw_timeout_returned", int'(ok), 1);
    chk("sw_memwr_cycles", n, 4);
    @(negedge clk);
    chk("sw_timeout_single", int'(if1.mem_timeout), 0);
    chk("sw_state_fetch", int'(if1.state_dbg), 0);
    #1 mem_ready = 1'b1;

    // beq then j
    opcode = 6'b000100;
    wait_st(0, 8);
    chk("beq_alu_op", int'(if0.alu_op), 1);
    chk("beq_pc_write_cond", int'(if0.pc_write_cond), 1);
    chk("beq_pc_source", int'(if0.pc_source), 1);
    #1 opcode = 6'b000010;
    wait_st(0, 9);
    chk("j_pc_write", int'(if0.pc_write), 1);
    chk("j_pc_source", int'(if0.pc_source), 2);

    // Illegal opcodes
    #1 opcode = 6'b111111;
    wait_st(0, 1);
    @(negedge clk);
    chk("ill_state", int'(if0.state_dbg), 0);
    chk("ill_pulse", int'(if0.illegal_op), 1);
    @(negedge clk);
    chk("ill_pulse_end", int'(if0.illegal_op), 0);
    #1 opcode = 6'b001000;
    wait_st(1, 1);
    @(negedge clk);
    chk("addi_off_state", int'(if1.state_dbg), 0);
    chk("addi_off_pulse", int'(if1.illegal_op), 1);
    wait_st(0, 10);
    chk("addi_on_src_b", int'(if0.alu_src_b), 2);

    // Async reset during MEMWR
    #1 opcode = 6'b101011;
    wait_st(0, 2);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_state", int'(if0.state_dbg), 5);
    chk("rst_pre_mem_write", int'(if0.mem_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_mem_write", int'(if0.mem_write), 0);
    chk("rst_async_mem_read", int'(if0.mem_read), 0);
    chk("rst_async_state", int'(if0.state_dbg), 0);
    @(posedge clk); #3 rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_release_state", int'(if0.state_dbg), 0);

    // Randomised traffic with stalls and occasional async resets
    stall = 0; rst_hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      case ($urandom % 10)
        0: opcode = 6'b000000;
        1: opcode = 6'b100011;
        2: opcode = 6'b101011;
        3: opcode = 6'b000100;
        4: opcode = 6'b000010;
        5: opcode = 6'b001000;
        6: opcode = 6'b111111;
        7: opcode = 6'($urandom);
        default: opcode = opcode;
      endcase
      if (stall > 0) begin
        mem_ready = 1'b0; stall--;
      end else if ($urandom % 40 == 0) begin
        mem_ready = 1'b0; stall = $urandom_range(24, 2);
      end else begin
        mem_ready = ($urandom % 4 != 0);
      end
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) #2 rst_n = 1'b1;
      end else if ($urandom % 300 == 0) begin
        #2 rst_n = 1'b0;
        rst_hold = $urandom_range(3, 1);
      end
    end
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
